// File: rtl/note_sequencer_if.sv
// Control/data bundle for note_sequencer: requests and switch tones in,
// tone vector and status out. The master side is the controller.
interface note_sequencer_if #(
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_write;
  logic          i_read;
  logic          i_listen;
  logic [7:0]    i_sw_tones;
  logic [7:0]    o_tone_out;
  logic          o_finish;
  logic [CW-1:0] o_note_count;
  logic          o_full;
  logic          o_playing;

  modport master (
    output i_write, i_read, i_listen, i_sw_tones,
    input  o_tone_out, o_finish, o_note_count, o_full, o_playing
  );

  modport slave (
    input  i_write, i_read, i_listen, i_sw_tones,
    output o_tone_out, o_finish, o_note_count, o_full, o_playing
  );
endinterface

// File: rtl/note_sequencer.sv
// Records up to DEPTH switch-tone vectors and plays them back, each note held
// NOTE_TICKS cycles followed by GAP_TICKS silent cycles; live monitor when idle.
module note_sequencer #(
  parameter int DEPTH      = 32,
  parameter int NOTE_TICKS = 25000000,
  parameter int GAP_TICKS  = 2500000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  note_sequencer_if.slave   bus
);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_note_count;
  logic [TW-1:0] r_tick;
  logic [7:0]    r_tone_out;
  logic          r_finish;
  logic          r_playing;
  logic          r_prev_listen;

  logic [CW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_rd_ptr_inc;
  logic [TW-1:0] w_tick_nxt;
  logic [7:0]    w_tone_nxt;
  logic          w_finish_nxt;
  logic          w_playing_nxt;
  logic          w_full;
  logic          w_clear;
  logic          w_wr_accept;
  logic          w_mem_we;
  logic          w_note_end;
  logic          w_gap_end;
  logic          w_last_note;
  logic [7:0]    w_mem_first;
  logic [7:0]    w_mem_next;

  // A falling listen with read low starts a new recording session.
  assign w_full       = (r_note_count == CNT_DEPTH);
  assign w_clear      = r_prev_listen & ~bus.i_listen & ~bus.i_read;
  assign w_wr_accept  = bus.i_write & ~bus.i_read & ~w_full & ~w_clear & (r_state == ST_IDLE);
  assign w_mem_we     = w_wr_accept & ~i_reset;
  assign w_note_end   = (r_tick == NOTE_LAST);
  assign w_gap_end    = (r_tick == GAP_LAST);
  assign w_last_note  = (r_rd_ptr == (r_note_count - CNT_ONE));
  assign w_rd_ptr_inc = r_rd_ptr + CNT_ONE;
  assign w_mem_first  = r_mem[ADDR_ZERO];
  assign w_mem_next   = r_mem[w_rd_ptr_inc[AW-1:0]];

  assign bus.o_tone_out   = r_tone_out;
  assign bus.o_finish     = r_finish;
  assign bus.o_note_count = r_note_count;
  assign bus.o_full       = w_full;
  assign bus.o_playing    = r_playing;

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; dropping read aborts playback without a finish pulse.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!bus.i_read) begin
          w_state_nxt = ST_IDLE;
        end else if (r_note_count != CNT_ZERO) begin
          w_state_nxt = ST_PLAY;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_PLAY: begin
        if (!bus.i_read) begin
          w_state_nxt = ST_IDLE;
        end else if (w_note_end) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_GAP: begin
        if (!bus.i_read) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_gap_end) begin
          w_state_nxt = ST_GAP;
        end else if (w_last_note) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_DONE: begin
        if (!bus.i_read) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values for the registered outputs, tick counter and playback pointer.
  always_comb begin
    w_tone_nxt    = 8'h00;
    w_finish_nxt  = 1'b0;
    w_tick_nxt    = TICK_ZERO;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_playing_nxt = (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_GAP);
    case (r_state)
      ST_IDLE: begin
        if (bus.i_read) begin
          if (r_note_count != CNT_ZERO) begin
            w_tone_nxt   = w_mem_first;
            w_rd_ptr_nxt = CNT_ZERO;
          end else begin
            w_finish_nxt = 1'b1;
          end
        end else if (bus.i_listen) begin
          w_tone_nxt = bus.i_sw_tones;
        end else begin
          w_tone_nxt = 8'h00;
        end
      end
      ST_PLAY: begin
        if (bus.i_read && !w_note_end) begin
          w_tone_nxt = r_tone_out;
          w_tick_nxt = r_tick + TICK_ONE;
        end else begin
          w_tone_nxt = 8'h00;
        end
      end
      ST_GAP: begin
        if (!bus.i_read) begin
          w_tone_nxt = 8'h00;
        end else if (!w_gap_end) begin
          w_tick_nxt = r_tick + TICK_ONE;
        end else if (!w_last_note) begin
          w_rd_ptr_nxt = w_rd_ptr_inc;
          w_tone_nxt   = w_mem_next;
        end else begin
          w_finish_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        w_tone_nxt = 8'h00;
      end
      default: begin
        w_tone_nxt = 8'h00;
      end
    endcase
  end

  // Registered playback outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tone_out <= 8'h00;
      r_finish   <= 1'b0;
      r_playing  <= 1'b0;
      r_tick     <= TICK_ZERO;
      r_rd_ptr   <= CNT_ZERO;
    end else begin
      r_tone_out <= w_tone_nxt;
      r_finish   <= w_finish_nxt;
      r_playing  <= w_playing_nxt;
      r_tick     <= w_tick_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
    end
  end

  // Recording bookkeeping; a session clear outranks a coincident write.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr      <= CNT_ZERO;
      r_note_count  <= CNT_ZERO;
      r_prev_listen <= 1'b1;
    end else begin
      r_prev_listen <= bus.i_listen;
      if (w_clear) begin
        r_wr_ptr     <= CNT_ZERO;
        r_note_count <= CNT_ZERO;
      end else if (w_wr_accept) begin
        r_wr_ptr     <= r_wr_ptr + CNT_ONE;
        r_note_count <= r_note_count + CNT_ONE;
      end else begin
        r_wr_ptr     <= r_wr_ptr;
        r_note_count <= r_note_count;
      end
    end
  end

  // Note storage; contents survive reset and session clears.
  always_ff @(posedge i_clock) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.i_sw_tones;
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a playback-schedule model predicts each
// cycle's outputs, a monitor compares them after every rising edge.
module tb_note_sequencer;
  localparam int DEPTH = 4;
  localparam int NT    = 4;
  localparam int GT    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  note_sequencer_if #(.DEPTH(DEPTH)) bus ();

  note_sequencer #(.DEPTH(DEPTH), .NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [7:0]    tone;
    logic          fin;
    logic [CW-1:0] cnt;
    logic          full;
    logic          play;
  } obs_t;

  typedef struct packed {
    logic [7:0] tone;
    logic       fin;
    logic       play;
  } item_t;

  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;

  logic [7:0] notes [DEPTH];
  int         m_count = 0;
  int         m_mode = 0;       // 0 idle, 1 running a schedule, 2 done
  bit         m_prev_listen = 1'b1;
  item_t      sched[$];
  obs_t       m_out;

  // Playback is expanded into a per-cycle list of outputs when read is granted.
  task automatic model_step(input bit wr, input bit rd, input bit ls,
                            input logic [7:0] sw, input bit rs);
    item_t it;
    bit    clr;
    m_out.tone = 8'h00;
    m_out.fin  = 1'b0;
    m_out.play = 1'b0;
    if (rs) begin
      m_mode = 0;
      sched.delete();
      m_count = 0;
      m_prev_listen = 1'b1;
    end else begin
      clr = m_prev_listen && !ls && !rd;
      case (m_mode)
        0: begin
          if (rd) begin
            if (m_count > 0) begin
              for (int n = 0; n < m_count; n++) begin
                for (int t = 0; t < NT; t++) sched.push_back('{notes[n], 1'b0, 1'b1});
                for (int t = 0; t < GT; t++) sched.push_back('{8'h00, 1'b0, 1'b1});
              end
              sched.push_back('{8'h00, 1'b1, 1'b0});
              it = sched.pop_front();
              m_out.tone = it.tone;
              m_out.play = it.play;
              m_mode = 1;
            end else begin
              m_out.fin = 1'b1;
              m_mode = 2;
            end
          end else begin
            m_out.tone = ls ? sw : 8'h00;
            if (wr && m_count < DEPTH && !clr) begin
              notes[m_count] = sw;
              m_count++;
            end
          end
        end
        1: begin
          if (!rd) begin
            m_mode = 0;
            sched.delete();
          end else begin
            it = sched.pop_front();
            m_out.tone = it.tone;
            m_out.fin  = it.fin;
            m_out.play = it.play;
            if (it.fin) m_mode = 2;
          end
        end
        default: begin
          if (!rd) m_mode = 0;
        end
      endcase
      if (clr) m_count = 0;
      m_prev_listen = ls;
    end
    m_out.cnt  = CW'(m_count);
    m_out.full = (m_count == DEPTH);
  endtask

  task automatic drive(input bit wr, input bit rd, input bit ls,
                       input logic [7:0] sw, input bit rs);
    @(negedge clk);
    bus.i_write    = wr;
    bus.i_read     = rd;
    bus.i_listen   = ls;
    bus.i_sw_tones = sw;
    rst            = rs;
    model_step(wr, rd, ls, sw, rs);
    exp_q.push_back(m_out);
  endtask

  // Monitor: one expected entry per rising edge once stimulus is flowing.
  initial begin
    obs_t e;
    obs_t got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got.tone = bus.o_tone_out;
        got.fin  = bus.o_finish;
        got.cnt  = bus.o_note_count;
        got.full = bus.o_full;
        got.play = bus.o_playing;
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t tone got %h exp %h fin got %b exp %b cnt got %0d exp %0d full got %b exp %b play got %b exp %b",
                   $time, got.tone, e.tone, got.fin, e.fin, got.cnt, e.cnt,
                   got.full, e.full, got.play, e.play);
        end
      end
    end
  end

  initial begin
    bit         r_rd;
    bit         r_ls;
    logic [7:0] sw;
    bus.i_write    = 1'b0;
    bus.i_read     = 1'b0;
    bus.i_listen   = 1'b1;
    bus.i_sw_tones = 8'h00;

    drive(0, 0, 1, 8'h00, 1);
    drive(0, 0, 1, 8'h00, 1);
    // Live monitor
    drive(0, 0, 1, 8'h80, 0);
    drive(0, 0, 1, 8'h3c, 0);
    // Empty playback straight after reset
    repeat (3) drive(0, 1, 1, 8'h00, 0);
    drive(0, 0, 1, 8'h00, 0);
    // Record three notes then play them out fully
    drive(0, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h01, 0);
    drive(0, 0, 0, 8'h55, 0);
    drive(1, 0, 0, 8'h02, 0);
    drive(1, 0, 0, 8'h04, 0);
    repeat (22) drive(0, 1, 0, 8'h00, 0);
    drive(0, 0, 0, 8'h00, 0);
    // Overflow: five writes, only four kept
    drive(0, 0, 1, 8'h00, 0);
    drive(0, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h10, 0);
    drive(1, 0, 0, 8'h20, 0);
    drive(1, 0, 0, 8'h40, 0);
    drive(1, 0, 0, 8'h80, 0);
    drive(1, 0, 0, 8'hff, 0);
    repeat (27) drive(0, 1, 0, 8'h00, 0);
    drive(0, 0, 0, 8'h00, 0);
    // Abort during the second note
    repeat (8) drive(0, 1, 0, 8'h00, 0);
    repeat (3) drive(0, 0, 0, 8'h00, 0);
    // New session, clear coinciding with a write, then playback from address 0
    drive(0, 0, 1, 8'h00, 0);
    drive(0, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'haa, 0);
    drive(1, 0, 0, 8'hbb, 0);
    drive(0, 0, 1, 8'h00, 0);
    drive(1, 0, 0, 8'h77, 0);
    drive(1, 0, 0, 8'hcc, 0);
    repeat (9) drive(0, 1, 0, 8'h00, 0);
    drive(0, 0, 0, 8'h00, 0);
    // Reset in the middle of playback
    repeat (3) drive(0, 1, 0, 8'h00, 0);
    drive(0, 1, 1, 8'h00, 1);
    repeat (2) drive(0, 1, 1, 8'h00, 0);
    drive(0, 0, 1, 8'h00, 0);

    r_rd = 1'b0;
    r_ls = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) r_rd = ~r_rd;
      if ($urandom_range(0, 11) == 0) r_ls = ~r_ls;
      sw = 8'($urandom);
      drive(($urandom_range(0, 2) == 0), r_rd, r_ls, sw, ($urandom_range(0, 399) == 0));
    end

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter DEPTH, default 32, number of stored notes.
REQ-002 Parameter NOTE_TICKS, default 25000000, clock cycles each note is held during playback.
REQ-003 Parameter GAP_TICKS, default 2500000, silent clock cycles after each note.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 write  input  1  one-cycle request to store swTones.
REQ-007 read  input  1  level; high requests playback.
REQ-008 listen  input  1  level; high means idle/live mode.
REQ-009 swTones  input  8  switch tone vector.
REQ-010 tone_out  output  8  registered tone vector to the audio generator.
REQ-011 finish  output  1  one-cycle pulse at end of playback.
REQ-012 note_count  output  clog2(DEPTH)+1  stored note count.
REQ-013 full  output  1  high when note_count == DEPTH.
REQ-014 playing  output  1  high in PLAY or GAP.

Function
REQ-015 Storage SHALL be DEPTH x 8 memory with write pointer wr_ptr and playback pointer rd_ptr.
REQ-016 States SHALL be IDLE, PLAY, GAP, DONE, with one tick counter wide enough for max(NOTE_TICKS, GAP_TICKS).
REQ-017 Write, accepted only in IDLE with read low and full low: mem[wr_ptr] <= swTones; wr_ptr and note_count increment; effect visible the next cycle.
REQ-018 Write while full, or while read high, SHALL be ignored; wr_ptr does not wrap.
REQ-019 A listen 1->0 transition with read low (new recording session) SHALL clear note_count and wr_ptr to 0 the next cycle; memory contents are not erased.
REQ-020 If a clear and a write coincide, the clear SHALL take priority.
REQ-021 IDLE with listen high and read low: tone_out <= swTones every cycle (live monitor).
REQ-022 IDLE with listen low and read low: tone_out <= 0.
REQ-023 IDLE, read sampled high at edge k, note_count > 0: state <= PLAY, rd_ptr <= 0, tone_out <= mem[0], tick <= 0 at edge k.
REQ-024 IDLE, read sampled high, note_count == 0: state <= DONE and finish <= 1 at the same edge, tone_out <= 0.
REQ-025 PLAY: tone_out SHALL hold mem[rd_ptr] for exactly NOTE_TICKS cycles, then state <= GAP and tone_out <= 0.
REQ-026 GAP: tone_out SHALL be 0 for exactly GAP_TICKS cycles.
REQ-026a GAP end, rd_ptr < note_count-1: rd_ptr increments, state <= PLAY, and tone_out <= the next note.
REQ-027 GAP end, rd_ptr == note_count-1: state <= DONE and finish <= 1 for exactly one cycle.
REQ-028 DONE: tone_out = 0, finish = 0 after the first cycle; return to IDLE when read is sampled low.
REQ-029 Read going low in PLAY or GAP (aborted playback): state <= IDLE, tone_out <= 0 next edge, no finish pulse.
REQ-030 playing SHALL be registered with state; full SHALL be combinational from note_count.

Reset
REQ-031 Reset SHALL force state IDLE, tone_out 0, finish 0, playing 0, note_count 0, wr_ptr 0, rd_ptr 0, tick 0.
REQ-032 Reset SHALL set the internal previous-listen register to 1, so that no clear fires on the first cycle.
REQ-033 Reset SHALL take priority over every other input.
REQ-034 Reset SHALL abort playback immediately.

Verification (DEPTH=4, NOTE_TICKS=4, GAP_TICKS=2)
REQ-035 Record then play: drop listen, write 8'h01, 8'h02, 8'h04, raise read -> tone_out = 01 x4, 00 x2, 02 x4, 00 x2, 04 x4, 00 x2, then finish for 1 cycle; note_count = 3.
REQ-036 Overflow: drop listen, write 5 tones -> note_count = 4, full = 1, fifth tone absent from playback.
REQ-037 Empty playback: after reset, raise read -> finish = 1 on the first edge read is high, tone_out stays 0, playing stays 0.
REQ-038 Abort: lower read during the second note -> tone_out = 0 next cycle, no finish, state IDLE, note_count unchanged.
REQ-039 New session: record 2 notes, raise listen, then lower it with read low -> note_count = 0 next cycle; a write then stores at address 0.
REQ-040 Live and reset: listen high, swTones = 8'h80 -> tone_out = 80 one cycle later; reset asserted mid-PLAY -> all outputs 0 next cycle.
